// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the
// architectural fetch PC and the IF/ID pipeline register. Each edge it loads
// the next PC chosen by the ID-stage next-PC logic. It flags fetch address
// errors (AdEL) and inserts bubbles on exception entry and eret. It holds on
// interlock stalls.
//
// Ports
//   clk        in   1   system clock, rising-edge active
//   reset      in   1   synchronous active-high reset
//   stall      in   1   hazard interlock; holds F_PC and IF/ID
//   req        in   1   CP0 exception/interrupt request; fetch EXC_ENTRY
//   PCnxt      in  32   next fetch address from ID-stage next-PC logic
//   nxtBD      in   1   instruction now in IF is a delay slot
//   flush      in   1   eret in ID; instruction now in IF is wrong-path
//   IM_instr   in  32   instruction memory read data for F_PC
//   F_PC       out 32   current fetch PC
//   D_instr    out 32   IF/ID instruction
//   D_PC       out 32   IF/ID PC
//   D_BD       out  1   IF/ID delay-slot flag
//   D_excCode  out  5   IF/ID exception code (0 none, 4 AdEL)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_TOP    = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic [31:0] PCnxt,
    input  logic        nxtBD,
    input  logic        flush,
    input  logic [31:0] IM_instr,
    output logic [31:0] F_PC,
    output logic [31:0] D_instr,
    output logic [31:0] D_PC,
    output logic        D_BD,
    output logic [4:0]  D_excCode
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] f_pc_q,    f_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q,    d_pc_d;
    logic        d_bd_q,    d_bd_d;
    logic [4:0]  d_exc_q,   d_exc_d;

    logic        f_adel_s;
    logic [31:0] f_instr_s;
    logic [4:0]  f_exc_s;

    // Fetch address check and the word/exception code handed to IF/ID.
    always_comb begin
        f_adel_s  = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) || (f_pc_q > IM_TOP);
        f_instr_s = IM_instr;
        f_exc_s   = EXC_NONE;
        if (f_adel_s) begin
            // A faulting fetch must not leak memory data into decode.
            f_instr_s = 32'h0000_0000;
            f_exc_s   = EXC_ADEL;
        end else begin
            f_instr_s = IM_instr;
            f_exc_s   = EXC_NONE;
        end
    end

    // Next-state selection: req > stall > flush > normal advance.
    always_comb begin
        f_pc_d    = f_pc_q;
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        d_bd_d    = d_bd_q;
        d_exc_d   = d_exc_q;
        if (req) begin
            f_pc_d    = EXC_ENTRY;
            d_instr_d = 32'h0000_0000;
            d_pc_d    = EXC_ENTRY;
            d_bd_d    = 1'b0;
            d_exc_d   = EXC_NONE;
        end else if (stall) begin
            // Hold everything; an eret stalled on an EPC hazard waits here.
            f_pc_d    = f_pc_q;
            d_instr_d = d_instr_q;
            d_pc_d    = d_pc_q;
            d_bd_d    = d_bd_q;
            d_exc_d   = d_exc_q;
        end else if (flush) begin
            // Bubble carries the EPC target as its PC.
            f_pc_d    = PCnxt;
            d_instr_d = 32'h0000_0000;
            d_pc_d    = PCnxt;
            d_bd_d    = 1'b0;
            d_exc_d   = EXC_NONE;
        end else begin
            // Bad PCs are latched unchanged; the error travels as excCode.
            f_pc_d    = PCnxt;
            d_instr_d = f_instr_s;
            d_pc_d    = f_pc_q;
            d_bd_d    = nxtBD;
            d_exc_d   = f_exc_s;
        end
    end

    // PC and IF/ID register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q    <= RESET_PC;
            d_instr_q <= 32'h0000_0000;
            d_pc_q    <= 32'h0000_0000;
            d_bd_q    <= 1'b0;
            d_exc_q   <= EXC_NONE;
        end else begin
            f_pc_q    <= f_pc_d;
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            d_bd_q    <= d_bd_d;
            d_exc_q   <= d_exc_d;
        end
    end

    assign F_PC      = f_pc_q;
    assign D_instr   = d_instr_q;
    assign D_PC      = d_pc_q;
    assign D_BD      = d_bd_q;
    assign D_excCode = d_exc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. The instruction memory returns
// F_PC ^ 32'hDEAD_0000. This gives an expected IM word that can be worked
// out by hand for any address.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        req;
    logic [31:0] PCnxt;
    logic        nxtBD;
    logic        flush;
    logic [31:0] IM_instr;
    logic [31:0] F_PC;
    logic [31:0] D_instr;
    logic [31:0] D_PC;
    logic        D_BD;
    logic [4:0]  D_excCode;

    int n_checks;
    int n_pass;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .PCnxt     (PCnxt),
        .nxtBD     (nxtBD),
        .flush     (flush),
        .IM_instr  (IM_instr),
        .F_PC      (F_PC),
        .D_instr   (D_instr),
        .D_PC      (D_PC),
        .D_BD      (D_BD),
        .D_excCode (D_excCode)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory model.
    always_comb IM_instr = F_PC ^ 32'hDEAD_0000;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic bd, input logic [4:0] exc);
        check_val({tag, ".D_instr"}, D_instr, instr);
        check_val({tag, ".D_PC"}, D_PC, pc);
        check_val({tag, ".D_BD"}, {31'd0, D_BD}, {31'd0, bd});
        check_val({tag, ".D_exc"}, {27'd0, D_excCode}, {27'd0, exc});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1; stall = 1'b0; req = 1'b0; flush = 1'b0;
        PCnxt = 32'h0000_0000; nxtBD = 1'b0;
        #1;
        step();
        step();
        check_val("rst.F_PC", F_PC, 32'h0000_3000);
        check_d("rst", 32'h0, 32'h0, 1'b0, 5'd0);

        // Free-run.
        reset = 1'b0; PCnxt = 32'h0000_3004;
        step();
        check_val("run1.F_PC", F_PC, 32'h0000_3004);
        check_d("run1", 32'hDEAD_3000, 32'h0000_3000, 1'b0, 5'd0);
        PCnxt = 32'h0000_3008;
        step();
        check_val("run2.F_PC", F_PC, 32'h0000_3008);
        check_d("run2", 32'hDEAD_3004, 32'h0000_3004, 1'b0, 5'd0);

        // Branch with delay slot.
        PCnxt = 32'h0000_3010;
        step();
        check_val("br0.F_PC", F_PC, 32'h0000_3010);
        PCnxt = 32'h0000_3040; nxtBD = 1'b1;
        step();
        check_val("br1.F_PC", F_PC, 32'h0000_3040);
        check_d("br1", 32'hDEAD_3010, 32'h0000_3010, 1'b1, 5'd0);
        PCnxt = 32'h0000_3044; nxtBD = 1'b0;
        step();
        check_d("br2", 32'hDEAD_3040, 32'h0000_3040, 1'b0, 5'd0);

        // Stall hold; nxtBD and PCnxt must be ignored.
        PCnxt = 32'h0000_3020;
        step();
        check_val("st0.F_PC", F_PC, 32'h0000_3020);
        stall = 1'b1; PCnxt = 32'h0000_3024; nxtBD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("st.F_PC", F_PC, 32'h0000_3020);
            check_d("st", 32'hDEAD_3044, 32'h0000_3044, 1'b0, 5'd0);
        end
        stall = 1'b0; nxtBD = 1'b0;
        step();
        check_val("st_rel.F_PC", F_PC, 32'h0000_3024);
        check_d("st_rel", 32'hDEAD_3020, 32'h0000_3020, 1'b0, 5'd0);

        // Eret flush.
        PCnxt = 32'h0000_3050;
        step();
        check_val("fl0.F_PC", F_PC, 32'h0000_3050);
        flush = 1'b1; PCnxt = 32'h0000_3100; nxtBD = 1'b1;
        step();
        check_val("fl1.F_PC", F_PC, 32'h0000_3100);
        check_d("fl1", 32'h0, 32'h0000_3100, 1'b0, 5'd0);
        flush = 1'b0; nxtBD = 1'b0; PCnxt = 32'h0000_3104;
        step();
        check_d("fl2", 32'hDEAD_3100, 32'h0000_3100, 1'b0, 5'd0);
        // Flush under stall is ignored.
        stall = 1'b1; flush = 1'b1; PCnxt = 32'h0000_3200;
        step();
        check_val("flst.F_PC", F_PC, 32'h0000_3104);
        check_d("flst", 32'hDEAD_3100, 32'h0000_3100, 1'b0, 5'd0);

        // Fetch address errors.
        stall = 1'b0; flush = 1'b0; PCnxt = 32'h0000_3002;
        step();
        check_val("ad0.F_PC", F_PC, 32'h0000_3002);
        PCnxt = 32'h0000_7000;
        step();
        check_val("ad1.F_PC", F_PC, 32'h0000_7000);
        check_d("ad1", 32'h0, 32'h0000_3002, 1'b0, 5'd4);
        PCnxt = 32'h0000_6ffc; nxtBD = 1'b1;
        step();
        check_d("ad2", 32'h0, 32'h0000_7000, 1'b1, 5'd4);
        PCnxt = 32'h0000_2ffc; nxtBD = 1'b0;
        step();
        check_d("ad3", 32'hDEAD_6FFC, 32'h0000_6ffc, 1'b0, 5'd0);
        PCnxt = 32'h0000_3000;
        step();
        check_d("ad4", 32'h0, 32'h0000_2ffc, 1'b0, 5'd4);

        // Exception entry overrides stall and flush.
        req = 1'b1; stall = 1'b1; flush = 1'b1; nxtBD = 1'b1; PCnxt = 32'h0000_3300;
        step();
        check_val("req1.F_PC", F_PC, 32'h0000_4180);
        check_d("req1", 32'h0, 32'h0000_4180, 1'b0, 5'd0);
        stall = 1'b0; flush = 1'b0;
        step();
        check_val("req2.F_PC", F_PC, 32'h0000_4180);
        check_d("req2", 32'h0, 32'h0000_4180, 1'b0, 5'd0);
        req = 1'b0; nxtBD = 1'b0; PCnxt = 32'h0000_4184;
        step();
        check_val("req3.F_PC", F_PC, 32'h0000_4184);
        check_d("req3", 32'hDEAD_4180, 32'h0000_4180, 1'b0, 5'd0);

        // Reset beats req.
        reset = 1'b1; req = 1'b1; stall = 1'b1;
        step();
        check_val("rstreq.F_PC", F_PC, 32'h0000_3000);
        check_d("rstreq", 32'h0, 32'h0, 1'b0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
